// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the pipe_stage_buf stage buffer
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers stay one bit wide for a single-entry buffer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

    function automatic occ_e occ_state(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0) begin
            return EMPTY;
        end
        if (cnt >= depth) begin
            return FULL;
        end
        return PARTIAL;
    endfunction

endpackage

// File: rtl/pipe_stage_mem.sv
// rtl/pipe_stage_mem.sv - DEPTH x WIDTH payload array, one write port, async read
module pipe_stage_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately left unreset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - valid/ready circular stage buffer with flush and occupancy
// Optional zero-latency bypass when empty: define PIPE_STAGE_BYPASS_EN.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rdata;
    logic             empty, full, push, pop, byp, store, take;
    occ_e             occ;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign s_ready = ~full & ~flush;

`ifdef PIPE_STAGE_BYPASS_EN
    assign byp = empty & s_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    assign m_valid = (~empty & ~flush) | byp;
    assign m_data  = byp ? s_data : rdata;
    assign count   = count_q;

    assign push  = s_valid & s_ready;
    assign pop   = m_valid & m_ready;
    // A bypassed payload that is consumed the same cycle never touches storage.
    assign store = push & ~(byp & m_ready);
    assign take  = pop & ~byp;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (store) begin
                tail_d = PTR_W'(ptr_inc(32'(tail_q), DEPTH));
            end
            if (take) begin
                head_d = PTR_W'(ptr_inc(32'(head_q), DEPTH));
            end
            case ({store, take})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    pipe_stage_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_mem (
        .clk  (clk),
        .wen  (store),
        .waddr(tail_q),
        .wdata(s_data),
        .raddr(head_q),
        .rdata(rdata)
    );

    assign occ = occ_state(32'(count_q), DEPTH);

    a_cnt_range: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_FULL);
    a_full_stall: assert property (@(posedge clk) disable iff (rst) (occ == FULL) |-> !s_ready);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - randomized and directed bench for DEPTH=1/2/3 stage buffers
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush   [3];
    logic        s_valid [3];
    logic        m_ready [3];
    logic        s_ready [3];
    logic        m_valid [3];
    logic [31:0] s_data  [3];
    logic [31:0] m_data  [3];
    logic [0:0]  cnt_d1;
    logic [1:0]  cnt_d2;
    logic [1:0]  cnt_d3;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q [3][$];
    int          pop_cnt  [3];
    int          last_pop [3];
    bit          accepted [3];
    int          cyc = 0;
    logic [31:0] popped [$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
        .count(cnt_d1));
    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
        .count(cnt_d2));
    pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .s_data(s_data[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]),
        .count(cnt_d3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int depth_of(input int k);
        return k + 1;
    endfunction

    function automatic logic [31:0] cnt_of(input int k);
        case (k)
            0:       return {31'd0, cnt_d1};
            1:       return {30'd0, cnt_d2};
            default: return {30'd0, cnt_d3};
        endcase
    endfunction

    task automatic idle(input int k);
        flush[k]   = 1'b0;
        s_valid[k] = 1'b0;
        m_ready[k] = 1'b0;
        s_data[k]  = 32'd0;
    endtask

    task automatic rand_in(input int k);
        flush[k]   = ($urandom_range(15) == 0);
        s_valid[k] = $urandom_range(1);
        m_ready[k] = $urandom_range(1);
        s_data[k]  = $urandom;
    endtask

    // One clock of the reference queue model: outputs checked at negedge, state moved at posedge.
    task automatic cycle();
        bit          push [3];
        bit          pop  [3];
        bit          byp  [3];
        logic [31:0] md   [3];
        bit          exp_mv, exp_sr;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            byp[k] = BYP && (q[k].size() == 0) && s_valid[k] && !flush[k];
            exp_mv = ((q[k].size() != 0) && !flush[k]) || byp[k];
            exp_sr = (q[k].size() < depth_of(k)) && !flush[k];
            md[k]  = byp[k] ? s_data[k] : ((q[k].size() != 0) ? q[k][0] : 32'd0);
            if (!rst) begin
                check($sformatf("m_valid%0d@%0d", k, cyc), {31'd0, m_valid[k]}, {31'd0, exp_mv});
                check($sformatf("s_ready%0d@%0d", k, cyc), {31'd0, s_ready[k]}, {31'd0, exp_sr});
                check($sformatf("count%0d@%0d", k, cyc), cnt_of(k), 32'(q[k].size()));
                if (exp_mv) begin
                    check($sformatf("m_data%0d@%0d", k, cyc), m_data[k], md[k]);
                end
            end
            push[k]     = s_valid[k] && exp_sr;
            pop[k]      = exp_mv && m_ready[k];
            accepted[k] = push[k] && !rst;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst || flush[k]) begin
                q[k].delete();
            end else begin
                if (pop[k]) begin
                    pop_cnt[k]++;
                    last_pop[k] = cyc;
                    if (k == 1) popped.push_back(md[k]);
                end
                if (!(byp[k] && pop[k])) begin
                    if (pop[k]) void'(q[k].pop_front());
                    if (push[k]) q[k].push_back(s_data[k]);
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        int nxt [3];
        int base;
        int pushed;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(k);
            pop_cnt[k]  = 0;
            last_pop[k] = 0;
        end
        cycle();
        cycle();
        rst = 1'b0;

        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 3; k++) rand_in(k);
            cycle();
        end

        // Reset asserted for two cycles in the middle of traffic.
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) rand_in(k);
            cycle();
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) idle(k);
        #0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_m_valid%0d", k), {31'd0, m_valid[k]}, 32'd0);
            check($sformatf("rst_s_ready%0d", k), {31'd0, s_ready[k]}, 32'd1);
            check($sformatf("rst_count%0d", k), cnt_of(k), 32'd0);
        end
        cycle();

        // Back-pressure fill of the DEPTH=2 buffer, then ordered drain.
        popped.delete();
        s_valid[1] = 1'b1;
        s_data[1]  = 32'hA;
        cycle();
        s_data[1]  = 32'hB;
        cycle();
        s_valid[1] = 1'b0;
        #0;
        check("bp_count", cnt_of(1), 32'd2);
        check("bp_s_ready", {31'd0, s_ready[1]}, 32'd0);
        m_ready[1] = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        check("bp_npop", 32'(popped.size()), 32'd2);
        if (popped.size() == 2) begin
            check("bp_first", popped[0], 32'hA);
            check("bp_second", popped[1], 32'hB);
        end
        check("bp_count_end", cnt_of(1), 32'd0);
        idle(1);

        // Streaming 1..100 into every depth with the consumer always ready.
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            nxt[k]     = 1;
            pop_cnt[k] = 0;
        end
        for (int c = 0; c < 202; c++) begin
            for (int k = 0; k < 3; k++) begin
                s_valid[k] = (nxt[k] <= 100);
                s_data[k]  = 32'(nxt[k]);
                m_ready[k] = 1'b1;
            end
            cycle();
            for (int k = 0; k < 3; k++) if (accepted[k]) nxt[k]++;
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stream_npop%0d", k), 32'(pop_cnt[k]), 32'd100);
            check($sformatf("stream_last%0d", k), 32'(last_pop[k]),
                  BYP ? 32'd99 : ((k == 0) ? 32'd199 : 32'd100));
            idle(k);
        end

        // DEPTH=3: ten pushes with random back-pressure exercise the 2->0 wrap.
        base   = pop_cnt[2];
        pushed = 0;
        for (int c = 0; c < 200; c++) begin
            s_valid[2] = (pushed < 10);
            s_data[2]  = 32'h300 + 32'(pushed);
            m_ready[2] = $urandom_range(1);
            cycle();
            if (accepted[2]) pushed++;
        end
        check("wrap_npop", 32'(pop_cnt[2] - base), 32'd10);
        idle(2);

        // Flush with two held entries and a same-cycle push.
        popped.delete();
        s_valid[1] = 1'b1;
        s_data[1]  = 32'h111;
        cycle();
        s_data[1]  = 32'h222;
        cycle();
        flush[1]   = 1'b1;
        s_data[1]  = 32'hDEAD;
        m_ready[1] = 1'b1;
        #0;
        check("flush_m_valid", {31'd0, m_valid[1]}, 32'd0);
        check("flush_s_ready", {31'd0, s_ready[1]}, 32'd0);
        cycle();
        flush[1] = 1'b0;
        s_data[1] = 32'h333;
        #0;
        check("flush_count", cnt_of(1), 32'd0);
        cycle();
        s_valid[1] = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        check("flush_npop", 32'(popped.size()), 32'd1);
        if (popped.size() == 1) check("flush_survivor", popped[0], 32'h333);
        idle(1);

`ifdef PIPE_STAGE_BYPASS_EN
        s_valid[0] = 1'b1;
        s_data[0]  = 32'h55;
        m_ready[0] = 1'b1;
        #0;
        check("byp_m_valid", {31'd0, m_valid[0]}, 32'd1);
        check("byp_m_data", m_data[0], 32'h55);
        cycle();
        idle(0);
        #0;
        check("byp_count", cnt_of(0), 32'd0);
`endif

        for (int c = 0; c < 4; c++) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
